jk_bank_ctrl: RTL and testbench
===============================

# jk_bank_ctrl

Command-driven sequencer for a bank of JK flip-flop cells. It accepts one command at a time over a valid/ready handshake. It drives J/K onto a single addressed cell for a programmable number of consecutive cycles, then reports the resulting cell value. It sits between a host/control FSM and the JK storage, and is the only agent allowed to drive the cells' J/K inputs.

## Interface
Parameters:
- N_BITS, 8: number of JK cells in the bank (2..64).
- REP_W, 4: width of the repeat field.
- IDX_W, $clog2(N_BITS): width of the cell index (derived; not overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- res  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 HOLD, 01 CLR (J=0,K=1), 10 SET (J=1,K=0), 11 TOG (J=1,K=1).
- cmd_idx  in  IDX_W  target cell.
- cmd_rep  in  REP_W  extra applications; the op is applied cmd_rep+1 times.
- q  out  N_BITS  current cell values.
- busy  out  1  command in progress (APPLY or DONE).
- done  out  1  one-cycle completion pulse.
- done_q  out  1  q[idx] after the last application; valid only while done=1.
- err  out  1  qualifies done; index was out of range.
- tog_cnt  out  16  present only with JK_BANK_TOGCNT_EN.

## Operation
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready, latch op/idx/rep into the active registers and load rem=rep.
  - If idx >= N_BITS, set the err flag and go to DONE directly. No cell is touched.
  - Otherwise go to APPLY.
- APPLY:
  - Drive J/K per the latched op on cell idx only. All other cells get J=K=0.
  - If rem==0, go to DONE. Otherwise decrement rem and stay in APPLY.
- DONE:
  - done=1, done_q=q[idx], err=err flag. Return to IDLE.
- Cell behaviour (jk_cell):
  - J=0,K=0: hold. J=0,K=1: q=0. J=1,K=0: q=1. J=1,K=1: q=~q.
  - Cells update on the same clk edge.
- cmd_ready=0 in APPLY and DONE. No command is queued, and input fields are ignored while busy.
- HOLD ops still execute the full rep+1 APPLY cycles with J=K=0.
- rep counter width is REP_W. The maximum of 2^REP_W applications must not wrap early.

## Timing
- Reset (res=0 at edge):
  - State IDLE, all q=0, rem=0.
  - done=0, done_q=0, err=0, busy=0, tog_cnt=0.
  - cmd_ready=0 while res=0.
- Reset asserted mid-command aborts it: no done pulse, and cells clear on that edge.
- Handshake timeline, command accepted at edge E0:
  - APPLY occupies cycles E0..E0+rep.
  - q[idx] reflects each application at the edge ending that cycle.
  - done is high during cycle E0+rep+1. cmd_ready returns the cycle after.
  - Latency from acceptance to done: rep+2 edges. Out-of-range: done after 1 edge.
- Back-to-back: minimum command spacing is rep+3 cycles. cmd_ready is high in the cycle immediately after done.
- cmd_valid held high while busy has no effect. The next acceptance happens in IDLE with the then-current fields.

## Configuration
- JK_BANK_TOGCNT_EN defined:
  - tog_cnt port exists. It increments once per APPLY cycle with op=TOG and a valid index.
  - 16-bit, wraps 0xFFFF->0.
  - Cleared only by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package jk_pkg:
  - op enum (JK_HOLD, JK_CLR, JK_SET, JK_TOG).
  - FSM state enum.
  - Function mapping op to {J,K}.
- Sub-module jk_cell (clk, res, j, k, q), instantiated N_BITS times via generate. It is a synchronous active-low reset JK flip-flop.
- Top holds the FSM, active-command registers, J/K demux, and the optional counter.

## Test plan
- Reset: hold res=0 for 2 cycles after driving garbage commands -> q=0x00, cmd_ready=0, done never asserts; after release cmd_ready=1.
- SET idx=3 rep=0, then CLR idx=3 rep=2 -> q=0x08 after the first; done_q=1, done 2 edges after acceptance; the second gives q=0x00, done_q=0, done 4 edges after acceptance.
- TOG idx=0 rep=4 from q=0 -> q[0] sequence 1,0,1,0,1, final done_q=1; other bits unchanged; tog_cnt=5 with macro.
- Out-of-range: N_BITS=6, idx=7, any op -> done with err=1 one edge after acceptance, q unchanged.
- cmd_valid held high with changing fields during busy -> only the first command executes; the second command's fields are those present in IDLE.
- Reset asserted in the 2nd APPLY cycle of TOG rep=7 -> no done, q=0, tog_cnt=0, cmd_ready=1 the cycle after res=1.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types for the JK bank controller: command ops, FSM states, op-to-{J,K} map.
// Combinational only; no latency or backpressure.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_DONE  = 2'b10
  } jk_state_t;

  // Returns {J,K} for an op.
  function automatic logic [1:0] jk_op_to_jk(input jk_op_t op);
    logic [1:0] jk;
    case (op)
      JK_CLR:  jk = 2'b01;
      JK_SET:  jk = 2'b10;
      JK_TOG:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset.
// One-edge update; no backpressure.
module jk_cell (
  input  logic clk,
  input  logic res,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!res) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Sequencer applying one J/K op rep+1 times to one cell of a JK bank, then pulsing done.
// Latency rep+2 edges from acceptance (1 edge if index out of range); cmd_ready low while busy.
// Optional JK_BANK_TOGCNT_EN adds a 16-bit count of TOG applications.
module jk_bank_ctrl
  import jk_pkg::*;
#(
  parameter  int N_BITS = 8,
  parameter  int REP_W  = 4,
  localparam int IDX_W  = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_idx,
  input  logic [REP_W-1:0]  cmd_rep,
  output logic [N_BITS-1:0] q,
  output logic              busy,
  output logic              done,
  output logic              done_q,
  output logic              err
`ifdef JK_BANK_TOGCNT_EN
  ,
  output logic [15:0]       tog_cnt
`endif
);

  localparam logic [IDX_W:0] N_LIM = N_BITS[IDX_W:0];

  jk_state_t          state, state_n;
  jk_op_t             op_r;
  logic [IDX_W-1:0]   idx_r;
  logic [REP_W-1:0]   rem_r;
  logic               err_r;
  logic               accept;
  logic               cmd_oor;
  logic               apply;
  logic [1:0]         jk_sel;
  logic [N_BITS-1:0]  j_v, k_v;

  assign cmd_oor = {1'b0, cmd_idx} >= N_LIM;
  assign apply   = (state == ST_APPLY);
  assign jk_sel  = jk_op_to_jk(op_r);

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = res;
        accept    = cmd_valid && res;
        if (accept) state_n = cmd_oor ? ST_DONE : ST_APPLY;
      end
      ST_APPLY: begin
        busy = 1'b1;
        if (rem_r == '0) state_n = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = res;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // done_q is forced low on an error: idx_r may not name a real cell.
  assign done_q = done && !err_r && q[idx_r];
  assign err    = done && err_r;

  always_ff @(posedge clk) begin
    if (!res) begin
      state <= ST_IDLE;
      op_r  <= JK_HOLD;
      idx_r <= '0;
      rem_r <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_r  <= jk_op_t'(cmd_op);
        idx_r <= cmd_idx;
        rem_r <= cmd_rep;
        err_r <= cmd_oor;
      end else if (apply && rem_r != '0) begin
        rem_r <= rem_r - 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_BITS; i++) begin : g_cell
    assign j_v[i] = apply && (idx_r == IDX_W'(i)) && jk_sel[1];
    assign k_v[i] = apply && (idx_r == IDX_W'(i)) && jk_sel[0];
    jk_cell u_cell (
      .clk (clk),
      .res (res),
      .j   (j_v[i]),
      .k   (k_v[i]),
      .q   (q[i])
    );
  end

`ifdef JK_BANK_TOGCNT_EN
  // APPLY is only entered with an in-range index, so no extra qualification.
  always_ff @(posedge clk) begin
    if (!res) begin
      tog_cnt <= 16'd0;
    end else if (apply && op_r == JK_TOG) begin
      tog_cnt <= tog_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Randomized self-checking bench for jk_bank_ctrl (N_BITS=6 so index 6/7 are out of range).
module tb_jk_bank_ctrl;

  localparam int NB = 6;
  localparam int RW = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [IW-1:0] cmd_idx = '0;
  logic [RW-1:0] cmd_rep = '0;
  logic [NB-1:0] q;
  logic          busy, done, done_q, err;
`ifdef JK_BANK_TOGCNT_EN
  logic [15:0]   tog_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [NB-1:0] qm;
  int            togm;

  jk_bank_ctrl #(.N_BITS(NB), .REP_W(RW)) dut (
    .clk       (clk),
    .res       (res),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_idx   (cmd_idx),
    .cmd_rep   (cmd_rep),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .done_q    (done_q),
    .err       (err)
`ifdef JK_BANK_TOGCNT_EN
    ,
    .tog_cnt   (tog_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_tog();
`ifdef JK_BANK_TOGCNT_EN
    chk("tog_cnt", 32'(tog_cnt), 32'(togm & 32'hFFFF));
`endif
  endtask

  // Cell semantics: HOLD keeps, CLR -> 0, SET -> 1, TOG inverts.
  function automatic logic model_op(input logic [1:0] op, input logic v);
    case (op)
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      2'd3:    return ~v;
      default: return v;
    endcase
  endfunction

  task automatic garble();
    cmd_op  = 2'($urandom);
    cmd_idx = IW'($urandom);
    cmd_rep = RW'($urandom);
  endtask

  // Issue one command from an IDLE cycle and follow it to done, checking every edge.
  task automatic run_cmd(input logic [1:0] op, input logic [IW-1:0] idx,
                         input logic [RW-1:0] rep, input bit hold);
    bit oor;
    oor = int'(idx) >= NB;
    chk("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_rep   = rep;
    @(posedge clk); #1;
    cmd_valid = hold;
    garble();
    if (oor) begin
      chk("oor_done", 32'(done), 32'd1);
      chk("oor_err", 32'(err), 32'd1);
      chk("oor_q", 32'(q), 32'(qm));
    end else begin
      chk("busy", 32'(busy), 32'd1);
      chk("ready_busy", 32'(cmd_ready), 32'd0);
      chk("done_early", 32'(done), 32'd0);
      for (int a = 0; a <= int'(rep); a++) begin
        @(posedge clk); #1;
        garble();
        qm[idx] = model_op(op, qm[idx]);
        if (op == 2'd3) togm = togm + 1;
        chk("q_step", 32'(q), 32'(qm));
        chk("done_timing", 32'(done), (a == int'(rep)) ? 32'd1 : 32'd0);
      end
      chk("done_q", 32'(done_q), 32'(qm[idx]));
      chk("err_clear", 32'(err), 32'd0);
    end
    chk_tog();
    @(posedge clk); #1;
    chk("ready_after", 32'(cmd_ready), 32'd1);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    qm   = '0;
    togm = 0;

    // Reset with garbage commands presented.
    res       = 1'b0;
    cmd_valid = 1'b1;
    garble();
    repeat (3) begin
      @(posedge clk); #1;
      garble();
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done_q", 32'(done_q), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
    end
    chk_tog();
    cmd_valid = 1'b0;
    res = 1'b1;
    #1;
    chk("rel_ready", 32'(cmd_ready), 32'd1);

    // Directed sequences.
    run_cmd(2'd2, 3'd3, 4'd0, 1'b0);
    chk("set3_q", 32'(q), 32'h08);
    run_cmd(2'd1, 3'd3, 4'd2, 1'b0);
    chk("clr3_q", 32'(q), 32'h00);
    run_cmd(2'd3, 3'd0, 4'd4, 1'b0);
    chk("tog0_q", 32'(q), 32'h01);
    run_cmd(2'd0, 3'd4, 4'd2, 1'b0);
    run_cmd(2'd2, 3'd7, 4'd5, 1'b0);
    run_cmd(2'd3, 3'd6, 4'd0, 1'b0);
    chk("oor_untouched", 32'(q), 32'h01);
    run_cmd(2'd1, 3'd0, 4'd3, 1'b1);
    run_cmd(2'd2, 3'd5, 4'd1, 1'b0);
    chk("held_q", 32'(q), 32'h20);
    run_cmd(2'd3, 3'd1, 4'd15, 1'b0);

    // Randomized commands.
    repeat (40) begin
      run_cmd(2'($urandom), IW'($urandom), RW'($urandom_range(0, 15)),
              bit'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;

    // Reset in the 2nd APPLY cycle of TOG rep=7.
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_idx   = 3'd2;
    cmd_rep   = 4'd7;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 32'd1);
    res = 1'b0;
    @(posedge clk); #1;
    qm   = '0;
    togm = 0;
    chk("mid_q", 32'(q), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_busy_rst", 32'(busy), 32'd0);
    chk_tog();
    res = 1'b1;
    #1;
    chk("mid_ready_rel", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    chk("mid_no_done", 32'(done), 32'd0);
    chk("mid_ready_next", 32'(cmd_ready), 32'd1);
    run_cmd(2'd2, 3'd1, 4'd1, 1'b0);
    chk("recover_q", 32'(q), 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
